// File: rtl/sdram_stats_pkg.sv
// Shared definitions for the SDRAM statistics master: FSM state encoding
// and the byte-stride helper used for Avalon address arithmetic.
package sdram_stats_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_READ   = 3'd1,
      ST_DRAIN  = 3'd2,
      ST_WR_MAX = 3'd3,
      ST_WR_MIN = 3'd4,
      ST_DONE   = 3'd5
   } state_t;

   function automatic int unsigned bytes_per_word(input int unsigned data_w);
      return (data_w + 7) / 8;
   endfunction

endpackage

// File: rtl/sdram_stats_sample_buf.sv
// Small capture memory for the first received words of a scan, with a
// registered debug read port and both async (reset) and sync (new scan) clear.
module sdram_stats_sample_buf #(
   parameter int DATA_W = 16,
   parameter int DEPTH  = 16,
   parameter int IDX_W  = 4
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              i_clear,
   input  logic              i_wr_en,
   input  logic [IDX_W-1:0]  i_wr_idx,
   input  logic [DATA_W-1:0] i_wr_data,
   input  logic [IDX_W-1:0]  i_rd_idx,
   output logic [DATA_W-1:0] o_rd_data
);

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [DATA_W-1:0] r_rd_data;

   // Clearing on each scan start keeps stale words from an earlier scan from
   // looking like captures of the current one.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      end else if (i_clear) begin
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      end else if (i_wr_en) begin
         r_mem[i_wr_idx] <= i_wr_data;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_rd_data <= '0;
      else          r_rd_data <= r_mem[i_rd_idx];
   end

   assign o_rd_data = r_rd_data;

endmodule

// File: rtl/sdram_stats_master.sv
// Avalon-MM master that scans a block of SDRAM words with pipelined reads,
// computing max/min/sum (signed or unsigned) and optionally writing max/min back.
module sdram_stats_master
   import sdram_stats_pkg::*;
#(
   parameter int DATA_W    = 16,
   parameter int ADDR_W    = 32,
   parameter int CNT_W     = 16,
   parameter int MAX_PEND  = 4,
   parameter int DBG_DEPTH = 16,
   parameter int DBG_IDX_W = $clog2(DBG_DEPTH)
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    ready_in,
   input  logic [ADDR_W-1:0]       base_addr_in,
   input  logic [CNT_W-1:0]        word_count_in,
   input  logic                    signed_in,
   input  logic                    wb_en_in,
   input  logic [ADDR_W-1:0]       result_addr_in,
   output logic [ADDR_W-1:0]       avm_address,
   output logic                    avm_read,
   output logic                    avm_write,
   output logic [DATA_W-1:0]       avm_writedata,
   input  logic [DATA_W-1:0]       avm_readdata,
   input  logic                    avm_waitrequest,
   input  logic                    avm_readdatavalid,
   output logic                    done_out,
   output logic [DATA_W-1:0]       max_out,
   output logic [DATA_W-1:0]       min_out,
   output logic [DATA_W+CNT_W-1:0] sum_out,
   output logic [2:0]              state_out,
   input  logic [DBG_IDX_W-1:0]    debug_read_index_in,
   output logic [DATA_W-1:0]       debug_sample_out
);

   localparam int                PEND_W   = $clog2(MAX_PEND + 1);
   localparam int                SUM_W    = DATA_W + CNT_W;
   localparam logic [ADDR_W-1:0] BPW      = ADDR_W'(bytes_per_word(DATA_W));
   localparam logic [PEND_W-1:0] PEND_MAX = PEND_W'(MAX_PEND);

   state_t             r_state, w_next;
   logic [ADDR_W-1:0]  r_addr, r_result_addr;
   logic [CNT_W-1:0]   r_count, r_issued, r_received;
   logic [PEND_W-1:0]  r_pend;
   logic               r_signed, r_wb_en;
   logic [DATA_W-1:0]  r_max, r_min;
   logic [SUM_W-1:0]   r_sum;

   logic               w_start, w_rd_ok, w_accept, w_rx, w_cap, w_gt, w_lt;
   logic [SUM_W-1:0]   w_rx_ext;

   assign w_start  = (r_state == ST_IDLE) && ready_in;
   assign w_rd_ok  = (r_state == ST_READ) && (r_issued < r_count) && (r_pend < PEND_MAX);
   assign w_accept = w_rd_ok && !avm_waitrequest;
   // Returns outside READ/DRAIN belong to an abandoned scan and are dropped.
   assign w_rx     = avm_readdatavalid && (r_received < r_count) &&
                     ((r_state == ST_READ) || (r_state == ST_DRAIN));
   assign w_cap    = w_rx && (r_received < CNT_W'(DBG_DEPTH));
   assign w_rx_ext = {{CNT_W{r_signed & avm_readdata[DATA_W-1]}}, avm_readdata};
   assign w_gt     = r_signed ? ($signed(avm_readdata) > $signed(r_max)) : (avm_readdata > r_max);
   assign w_lt     = r_signed ? ($signed(avm_readdata) < $signed(r_min)) : (avm_readdata < r_min);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_state <= ST_IDLE;
      else          r_state <= w_next;
   end

   always_comb begin
      w_next        = r_state;
      avm_read      = 1'b0;
      avm_write     = 1'b0;
      avm_address   = '0;
      avm_writedata = '0;
      case (r_state)
         ST_IDLE: begin
            if (ready_in) w_next = (word_count_in == '0) ? ST_DONE : ST_READ;
         end
         ST_READ: begin
            avm_read    = w_rd_ok;
            avm_address = r_addr;
            if (w_accept && (r_issued == r_count - CNT_W'(1))) w_next = ST_DRAIN;
         end
         ST_DRAIN: begin
            if (r_received == r_count) w_next = r_wb_en ? ST_WR_MAX : ST_DONE;
         end
         ST_WR_MAX: begin
            avm_write     = 1'b1;
            avm_address   = r_result_addr;
            avm_writedata = r_max;
            if (!avm_waitrequest) w_next = ST_WR_MIN;
         end
         ST_WR_MIN: begin
            avm_write     = 1'b1;
            avm_address   = r_result_addr + BPW;
            avm_writedata = r_min;
            if (!avm_waitrequest) w_next = ST_DONE;
         end
         ST_DONE: begin
            if (!ready_in) w_next = ST_IDLE;
         end
         default: w_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_addr        <= '0;
         r_result_addr <= '0;
         r_count       <= '0;
         r_issued      <= '0;
         r_received    <= '0;
         r_pend        <= '0;
         r_signed      <= 1'b0;
         r_wb_en       <= 1'b0;
         r_max         <= '0;
         r_min         <= '0;
         r_sum         <= '0;
      end else if (w_start) begin
         r_addr        <= base_addr_in;
         r_result_addr <= result_addr_in;
         r_count       <= word_count_in;
         r_signed      <= signed_in;
         r_wb_en       <= wb_en_in;
         r_issued      <= '0;
         r_received    <= '0;
         r_pend        <= '0;
         r_max         <= '0;
         r_min         <= '0;
         r_sum         <= '0;
      end else begin
         if (w_accept) begin
            r_addr   <= r_addr + BPW;
            r_issued <= r_issued + CNT_W'(1);
         end
         if (w_accept && !w_rx)      r_pend <= r_pend + PEND_W'(1);
         else if (!w_accept && w_rx) r_pend <= r_pend - PEND_W'(1);
         if (w_rx) begin
            r_received <= r_received + CNT_W'(1);
            r_sum      <= r_sum + w_rx_ext;
            if (r_received == '0) begin
               r_max <= avm_readdata;
               r_min <= avm_readdata;
            end else begin
               if (w_gt) r_max <= avm_readdata;
               if (w_lt) r_min <= avm_readdata;
            end
         end
      end
   end

   sdram_stats_sample_buf #(
      .DATA_W (DATA_W),
      .DEPTH  (DBG_DEPTH),
      .IDX_W  (DBG_IDX_W)
   ) u_sample_buf (
      .clk       (clk),
      .reset_n   (reset_n),
      .i_clear   (w_start),
      .i_wr_en   (w_cap),
      .i_wr_idx  (r_received[DBG_IDX_W-1:0]),
      .i_wr_data (avm_readdata),
      .i_rd_idx  (debug_read_index_in),
      .o_rd_data (debug_sample_out)
   );

   assign done_out  = (r_state == ST_DONE);
   assign state_out = r_state;
   assign max_out   = r_max;
   assign min_out   = r_min;
   assign sum_out   = r_sum;

endmodule

// File: tb/tb_sdram_stats_master.sv
// Randomized bench for sdram_stats_master: an Avalon slave model with a word
// memory, random waitrequest and fixed-latency returns, plus a scan-level reference model.
module tb_sdram_stats_master;

   localparam int DATA_W    = 16;
   localparam int ADDR_W    = 32;
   localparam int CNT_W     = 16;
   localparam int MAX_PEND  = 4;
   localparam int DBG_DEPTH = 16;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        ready_in = 1'b0;
   logic [31:0] base_addr_in = '0;
   logic [15:0] word_count_in = '0;
   logic        signed_in = 1'b0;
   logic        wb_en_in = 1'b0;
   logic [31:0] result_addr_in = '0;
   logic [31:0] avm_address;
   logic        avm_read, avm_write;
   logic [15:0] avm_writedata;
   logic [15:0] avm_readdata = '0;
   logic        avm_waitrequest = 1'b0;
   logic        avm_readdatavalid = 1'b0;
   logic        done_out;
   logic [15:0] max_out, min_out;
   logic [31:0] sum_out;
   logic [2:0]  state_out;
   logic [3:0]  debug_read_index_in = '0;
   logic [15:0] debug_sample_out;

   always #5 clk = ~clk;

   sdram_stats_master #(
      .DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W),
      .MAX_PEND(MAX_PEND), .DBG_DEPTH(DBG_DEPTH)
   ) dut (
      .clk(clk), .reset_n(reset_n), .ready_in(ready_in),
      .base_addr_in(base_addr_in), .word_count_in(word_count_in),
      .signed_in(signed_in), .wb_en_in(wb_en_in), .result_addr_in(result_addr_in),
      .avm_address(avm_address), .avm_read(avm_read), .avm_write(avm_write),
      .avm_writedata(avm_writedata), .avm_readdata(avm_readdata),
      .avm_waitrequest(avm_waitrequest), .avm_readdatavalid(avm_readdatavalid),
      .done_out(done_out), .max_out(max_out), .min_out(min_out), .sum_out(sum_out),
      .state_out(state_out), .debug_read_index_in(debug_read_index_in),
      .debug_sample_out(debug_sample_out)
   );

   int total = 0;
   int bad = 0;

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      total++;
      if (observed !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   logic [15:0]  mem [256];
   int unsigned  cycle = 0;
   int unsigned  latency = 3;
   int unsigned  waitPct = 0;
   int unsigned  wrWait = 0;
   int unsigned  wrWaitCnt = 0;
   int unsigned  dueQ[$];
   logic [15:0]  dataQ[$];
   logic [31:0]  expAddr = '0;
   logic [31:0]  expWrAddr = '0;
   logic [15:0]  expWrMax = '0, expWrMin = '0;
   int           acceptCnt = 0, writeCnt = 0, peakPend = 0, collideErr = 0;
   logic         prevRdWait = 1'b0, prevWrWait = 1'b0;
   logic [31:0]  prevAddr = '0;
   logic [15:0]  prevData = '0;

   // Slave model: decide this cycle's response at the falling edge, so the
   // DUT samples it (and we know exactly what it accepts) at the next rising edge.
   always @(negedge clk) begin
      cycle++;
      if (prevRdWait && reset_n)
         checkOutput("rdHold", {avm_read, avm_address}, {1'b1, prevAddr});
      if (prevWrWait && reset_n)
         checkOutput("wrHold", {avm_write, avm_address, avm_writedata}, {1'b1, prevAddr, prevData});
      if (dueQ.size() > 0 && dueQ[0] <= cycle) begin
         avm_readdatavalid = 1'b1;
         avm_readdata      = dataQ.pop_front();
         void'(dueQ.pop_front());
      end else begin
         avm_readdatavalid = 1'b0;
         avm_readdata      = 16'($urandom);
      end
      if (avm_write) begin
         avm_waitrequest = (wrWaitCnt < wrWait);
         wrWaitCnt = avm_waitrequest ? wrWaitCnt + 1 : 0;
      end else begin
         avm_waitrequest = ($urandom_range(99) < waitPct);
      end
      if (avm_read && avm_write) collideErr++;
      if (avm_read && !avm_waitrequest) begin
         checkOutput("rdAddr", avm_address, expAddr);
         expAddr += 32'd2;
         acceptCnt++;
         dueQ.push_back(cycle + latency);
         dataQ.push_back(mem[avm_address[8:1]]);
         if (dueQ.size() > peakPend) peakPend = dueQ.size();
      end
      if (avm_write && !avm_waitrequest) begin
         if (writeCnt == 0) begin
            checkOutput("wrMaxAddr", avm_address, expWrAddr);
            checkOutput("wrMaxData", avm_writedata, expWrMax);
         end else begin
            checkOutput("wrMinAddr", avm_address, expWrAddr + 32'd2);
            checkOutput("wrMinData", avm_writedata, expWrMin);
         end
         writeCnt++;
      end
      prevRdWait = avm_read && avm_waitrequest;
      prevWrWait = avm_write && avm_waitrequest;
      prevAddr   = avm_address;
      prevData   = avm_writedata;
   end

   function automatic logic [15:0] wordAt(input logic [31:0] base, input int k);
      logic [31:0] a;
      a = base + 32'(2 * k);
      return mem[(a >> 1) % 256];
   endfunction

   task automatic computeModel(input logic [31:0] base, input int count, input logic sgn,
                               output logic [15:0] mx16, output logic [15:0] mn16, output logic [31:0] sum32);
      int mx, mn, v;
      longint s;
      logic [15:0] w;
      mx = 0; mn = 0; s = 0;
      for (int k = 0; k < count; k++) begin
         w = wordAt(base, k);
         v = sgn ? int'($signed(w)) : int'(w);
         if (k == 0) begin mx = v; mn = v; end
         else begin
            if (v > mx) mx = v;
            if (v < mn) mn = v;
         end
         s += v;
      end
      mx16 = mx[15:0];
      mn16 = mn[15:0];
      sum32 = s[31:0];
   endtask

   task automatic applyStimulus(input logic [31:0] base, input int count, input logic sgn, input logic wb,
                                input logic [31:0] resAddr, input int unsigned lat,
                                input int unsigned wPct, input int unsigned wWait);
      logic [15:0] eMax, eMin, eSample;
      logic [31:0] eSum;
      int n;
      computeModel(base, count, sgn, eMax, eMin, eSum);
      expAddr = base; acceptCnt = 0; writeCnt = 0;
      expWrAddr = resAddr; expWrMax = eMax; expWrMin = eMin;
      latency = lat; waitPct = wPct; wrWait = wWait; wrWaitCnt = 0;
      @(negedge clk);
      base_addr_in = base; word_count_in = 16'(count); signed_in = sgn;
      wb_en_in = wb; result_addr_in = resAddr; ready_in = 1'b1;
      n = 0;
      while (!done_out && n < 3000) begin
         @(negedge clk);
         n++;
      end
      checkOutput("done", done_out, 1'b1);
      if (count == 0) checkOutput("zeroLatency", n, 1);
      checkOutput("state", state_out, 3'd5);
      checkOutput("max", max_out, eMax);
      checkOutput("min", min_out, eMin);
      checkOutput("sum", sum_out, eSum);
      checkOutput("reads", acceptCnt, count);
      checkOutput("writes", writeCnt, wb ? 2 : 0);
      for (int i = 0; i < DBG_DEPTH; i++) begin
         debug_read_index_in = 4'(i);
         @(negedge clk);
         eSample = (i < count) ? wordAt(base, i) : 16'h0;
         checkOutput("sample", debug_sample_out, eSample);
      end
      ready_in = 1'b0;
      @(negedge clk);
      checkOutput("idleState", state_out, 3'd0);
      checkOutput("idleDone", done_out, 1'b0);
   endtask

   initial begin
      int n;
      for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
      mem[8'h20] = 16'h0005; mem[8'h21] = 16'hFFFF; mem[8'h22] = 16'h0003; mem[8'h23] = 16'h0009;
      repeat (3) @(negedge clk);
      checkOutput("rstState", state_out, 3'd0);
      checkOutput("rstBus", {avm_read, avm_write, avm_address, avm_writedata}, '0);
      checkOutput("rstStats", {done_out, max_out, min_out, sum_out}, '0);
      reset_n = 1'b1;

      applyStimulus(32'h40, 4, 1'b0, 1'b0, 32'h0, 1, 0, 0);
      checkOutput("uMax", max_out, 16'hFFFF);
      checkOutput("uMin", min_out, 16'h0003);
      checkOutput("uSum", sum_out, 32'h0001_0010);
      applyStimulus(32'h40, 4, 1'b1, 1'b0, 32'h0, 1, 0, 0);
      checkOutput("sMax", max_out, 16'h0009);
      checkOutput("sMin", min_out, 16'hFFFF);
      checkOutput("sSum", sum_out, 32'h0000_0010);
      applyStimulus(32'h40, 4, 1'b0, 1'b1, 32'h100, 2, 20, 2);
      applyStimulus(32'h200, 0, 1'b0, 1'b0, 32'h0, 3, 0, 0);
      applyStimulus(32'h300, 20, 1'b0, 1'b0, 32'h0, 3, 40, 0);

      for (int r = 0; r < 6; r++) begin
         applyStimulus({20'h0, 11'($urandom), 1'b0}, $urandom_range(1, 24), 1'($urandom),
                       1'($urandom), {20'h0, 11'($urandom), 1'b0},
                       $urandom_range(1, 4), $urandom_range(0, 50), $urandom_range(0, 2));
      end

      // Abandon a scan in DRAIN with returns still in flight.
      expAddr = 32'h80; acceptCnt = 0; latency = 3; waitPct = 0;
      @(negedge clk);
      base_addr_in = 32'h80; word_count_in = 16'd8; signed_in = 1'b0;
      wb_en_in = 1'b0; ready_in = 1'b1;
      n = 0;
      while (state_out != 3'd2 && n < 200) begin
         @(negedge clk);
         n++;
      end
      checkOutput("drainReached", state_out, 3'd2);
      #1;
      checkOutput("pendAtReset", dueQ.size() >= 2, 1'b1);
      reset_n = 1'b0;
      ready_in = 1'b0;
      #1;
      checkOutput("midRstState", state_out, 3'd0);
      checkOutput("midRstBus", {avm_read, avm_write, avm_address, avm_writedata}, '0);
      checkOutput("midRstStats", {done_out, max_out, min_out, sum_out}, '0);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      n = 0;
      while (dueQ.size() > 0 && n < 50) begin
         @(negedge clk);
         n++;
      end
      checkOutput("flushPend", dueQ.size(), 0);
      debug_read_index_in = 4'd0;
      repeat (2) @(negedge clk);
      checkOutput("lateIgnState", state_out, 3'd0);
      checkOutput("lateIgnStats", {max_out, min_out, sum_out}, '0);
      checkOutput("lateIgnSample", debug_sample_out, 16'h0);
      applyStimulus(32'h80, 8, 1'b1, 1'b1, 32'h400, 3, 25, 1);

      checkOutput("peakPend", peakPend <= MAX_PEND, 1'b1);
      checkOutput("rdWrCollide", collideErr, 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
